hazard_scoreboard: RTL and testbench

- Parametrised stall generator for the MIPS pipeline. It replaces instruction-decoding stall logic with a registered scoreboard.
- The scoreboard tracks every in-flight destination register, with its remaining Tnew, across NUM_STAGES post-decode stages.
- It owns the HI/LO multiply/divide busy countdown internally; the pipeline no longer supplies an external busy signal.
- It orders CP0 EPC writes against ERET. Sits beside the D stage; the D-stage decoder supplies pre-decoded fields, and stall freezes PC/F/D and bubbles E.

---
 rtl/hazard_scoreboard_if.sv | 39 +++
 rtl/hazard_scoreboard.sv | 116 +++++++++++
 tb/tb_hazard_scoreboard.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// D-stage decode fields into the hazard scoreboard and the stall
// and multiply/divide status it returns to the pipeline.
interface hazard_scoreboard_if #(
  parameter int TW = 2
);
  logic          flush;
  logic          d_valid;
  logic [4:0]    d_rs;
  logic [4:0]    d_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic [4:0]    d_dst;
  logic [TW-1:0] d_tnew;
  logic          d_md_start;
  logic          d_md_div;
  logic          d_hilo_use;
  logic          d_eret;
  logic          d_mtc0_epc;
  logic          stall;
  logic [3:0]    stall_cause;
  logic          md_busy;
  logic          md_done;

  modport master (
    output flush, d_valid, d_rs, d_rt,
    output d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
    output d_md_start, d_md_div, d_hilo_use,
    output d_eret, d_mtc0_epc,
    input  stall, stall_cause, md_busy, md_done
  );

  modport slave (
    input  flush, d_valid, d_rs, d_rt,
    input  d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
    input  d_md_start, d_md_div, d_hilo_use,
    input  d_eret, d_mtc0_epc,
    output stall, stall_cause, md_busy, md_done
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Registered in-flight destination scoreboard producing D-stage stalls,
// with an internal HI/LO busy countdown and EPC-write vs eret ordering.
module hazard_scoreboard #(
  parameter int NUM_STAGES   = 3,
  parameter int TW           = 2,
  parameter int MULT_CYCLES  = 5,
  parameter int DIV_CYCLES   = 10,
  parameter int CP0_WB_STAGE = 2
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave bus
);

  localparam int MAXL =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXL + 1);

  typedef struct packed {
    logic          v;
    logic [4:0]    dst;
    logic [TW-1:0] tnew;
    logic          epc;
    logic          md;
  } entry_t;

  entry_t        e [1:NUM_STAGES];
  logic [CW-1:0] cnt;
  logic          done_q;

  logic rs_hit;
  logic rt_hit;
  logic cp0_hit;
  logic rs_haz;
  logic rt_haz;
  logic hilo_haz;
  logic cp0_haz;
  logic stall;
  logic load;
  logic md_load;

  function automatic logic [TW-1:0] sat_dec(
    input logic [TW-1:0] x
  );
    return (x == '0) ? x : x - TW'(1);
  endfunction

  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    cp0_hit = 1'b0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      if (e[k].v && e[k].dst == bus.d_rs &&
          e[k].tnew > bus.d_tuse_rs)
        rs_hit = 1'b1;
      if (e[k].v && e[k].dst == bus.d_rt &&
          e[k].tnew > bus.d_tuse_rt)
        rt_hit = 1'b1;
      if (k <= CP0_WB_STAGE && e[k].v && e[k].epc)
        cp0_hit = 1'b1;
    end
  end

  // r0 is never a real dependency, even if an entry targets it
  assign rs_haz = bus.d_valid && (bus.d_rs != 5'd0) && rs_hit;
  assign rt_haz = bus.d_valid && (bus.d_rt != 5'd0) && rt_hit;

  assign hilo_haz = bus.d_valid && bus.d_hilo_use &&
                    ((cnt != '0) || (e[1].v && e[1].md));

  assign cp0_haz = bus.d_valid && bus.d_eret && cp0_hit;

  assign stall   = rs_haz | rt_haz | hilo_haz | cp0_haz;
  assign load    = bus.d_valid && !stall;
  assign md_load = load && bus.d_md_start;

  assign bus.stall       = stall;
  assign bus.stall_cause = {cp0_haz, hilo_haz, rt_haz, rs_haz};
  assign bus.md_busy     = (cnt != '0);
  assign bus.md_done     = done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 1; k <= NUM_STAGES; k++)
        e[k] <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (bus.flush) begin
      for (int k = 1; k <= NUM_STAGES; k++)
        e[k].v <= 1'b0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        e[k+1]      <= e[k];
        e[k+1].tnew <= sat_dec(e[k].tnew);
      end
      if (load) begin
        e[1].v    <= 1'b1;
        e[1].dst  <= bus.d_dst;
        e[1].tnew <= bus.d_tnew;
        e[1].epc  <= bus.d_mtc0_epc;
        e[1].md   <= bus.d_md_start;
      end else begin
        e[1] <= '0;
      end
      // a load can only happen at zero: the hilo stall blocks it otherwise
      if (md_load)
        cnt <= bus.d_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
      done_q <= (cnt == CW'(1)) && !md_load;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and model-driven checks of the hazard scoreboard stall,
// cause, HI/LO busy and done outputs.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic reset = 1'b0;

  hazard_scoreboard_if #(.TW(2)) bus ();

  hazard_scoreboard #(
    .NUM_STAGES(3), .TW(2), .MULT_CYCLES(5),
    .DIV_CYCLES(10), .CP0_WB_STAGE(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic [3:0] cause;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    int         c;
    logic [4:0] dst;
    int         tn;
    logic       epc;
  } rec_t;

  exp_t q[$];
  rec_t recs[$];
  int passed = 0;
  int total  = 0;
  int t      = 0;
  int md_end = -100;

  task automatic chk1(string tag, logic [3:0] o, logic [3:0] x);
    total++;
    assert (o === x) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, o, x);
  endtask

  task automatic chk(string tag);
    exp_t x;
    if (q.size() == 0) begin
      total++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
      return;
    end
    x = q.pop_front();
    chk1({tag, ".stall"}, {3'b0, bus.stall}, {3'b0, x.stall});
    chk1({tag, ".cause"}, bus.stall_cause, x.cause);
    chk1({tag, ".busy"}, {3'b0, bus.md_busy}, {3'b0, x.busy});
    chk1({tag, ".done"}, {3'b0, bus.md_done}, {3'b0, x.done});
  endtask

  task automatic cyc(string tag, logic s, logic [3:0] c,
                     logic b, logic dn);
    q.push_back('{s, c, b, dn});
    @(negedge clk);
    chk(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic v, logic [4:0] rs, logic [1:0] urs,
                     logic [4:0] rt, logic [1:0] urt,
                     logic [4:0] dst, logic [1:0] tn);
    bus.d_valid    = v;
    bus.d_rs       = rs;
    bus.d_tuse_rs  = urs;
    bus.d_rt       = rt;
    bus.d_tuse_rt  = urt;
    bus.d_dst      = dst;
    bus.d_tnew     = tn;
    bus.d_md_start = 1'b0;
    bus.d_md_div   = 1'b0;
    bus.d_hilo_use = 1'b0;
    bus.d_eret     = 1'b0;
    bus.d_mtc0_epc = 1'b0;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
  endtask

  initial begin
    bus.flush = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // reset state, with a real instruction in D
    drv(1'b1, 5'd2, 2'd0, 5'd3, 2'd0, 5'd4, 2'd1);
    cyc("reset", 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    repeat (3) cyc("drain0", 1'b0, 4'b0000, 1'b0, 1'b0);

    // load-use
    drv(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd2);
    cyc("lw", 1'b0, 4'b0000, 1'b0, 1'b0);
    drv(1'b1, 5'd2, 2'd1, 5'd0, 2'd3, 5'd3, 2'd1);
    cyc("loaduse", 1'b1, 4'b0001, 1'b0, 1'b0);
    cyc("loaduse_go", 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    repeat (3) cyc("drain1", 1'b0, 4'b0000, 1'b0, 1'b0);

    // branch after ALU
    drv(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1);
    cyc("addu", 1'b0, 4'b0000, 1'b0, 1'b0);
    drv(1'b1, 5'd0, 2'd3, 5'd5, 2'd0, 5'd0, 2'd0);
    cyc("beq", 1'b1, 4'b0010, 1'b0, 1'b0);
    cyc("beq_go", 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    repeat (3) cyc("drain2", 1'b0, 4'b0000, 1'b0, 1'b0);
    drv(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd1);
    cyc("addu_r0", 1'b0, 4'b0000, 1'b0, 1'b0);
    drv(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    cyc("beq_r0", 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    repeat (3) cyc("drain3", 1'b0, 4'b0000, 1'b0, 1'b0);

    // multiply then divide, each followed by mflo
    for (int m = 0; m < 2; m++) begin
      int lat;
      lat = (m == 0) ? 5 : 10;
      drv(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
      bus.d_md_start = 1'b1;
      bus.d_md_div   = (m == 1);
      bus.d_hilo_use = 1'b1;
      cyc("md_issue", 1'b0, 4'b0000, 1'b0, 1'b0);
      drv(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd1);
      bus.d_hilo_use = 1'b1;
      for (int i = 0; i < lat; i++)
        cyc("mflo_wait", 1'b1, 4'b0100, 1'b1, 1'b0);
      cyc("mflo_go", 1'b0, 4'b0000, 1'b0, 1'b1);
      idle();
      cyc("md_done_once", 1'b0, 4'b0000, 1'b0, 1'b0);
      repeat (2) cyc("drain4", 1'b0, 4'b0000, 1'b0, 1'b0);
    end

    // EPC write ordering against eret
    drv(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    bus.d_mtc0_epc = 1'b1;
    cyc("mtc0", 1'b0, 4'b0000, 1'b0, 1'b0);
    drv(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    bus.d_eret = 1'b1;
    cyc("eret_e1", 1'b1, 4'b1000, 1'b0, 1'b0);
    cyc("eret_e2", 1'b1, 4'b1000, 1'b0, 1'b0);
    cyc("eret_go", 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    repeat (3) cyc("drain5", 1'b0, 4'b0000, 1'b0, 1'b0);

    // flush with lw in e[1] and mult busy=3
    drv(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    bus.d_md_start = 1'b1;
    bus.d_hilo_use = 1'b1;
    cyc("fl_mult", 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    cyc("fl_idle", 1'b0, 4'b0000, 1'b1, 1'b0);
    drv(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd2);
    cyc("fl_lw", 1'b0, 4'b0000, 1'b1, 1'b0);
    idle();
    bus.flush = 1'b1;
    cyc("fl_edge", 1'b0, 4'b0000, 1'b1, 1'b0);
    bus.flush = 1'b0;
    drv(1'b1, 5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    cyc("fl_addu", 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    repeat (5) cyc("fl_nodone", 1'b0, 4'b0000, 1'b0, 1'b0);

    // stall and flush in the same cycle
    drv(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd2);
    cyc("sf_lw", 1'b0, 4'b0000, 1'b0, 1'b0);
    drv(1'b1, 5'd4, 2'd1, 5'd0, 2'd3, 5'd6, 2'd1);
    bus.flush = 1'b1;
    cyc("sf_both", 1'b1, 4'b0001, 1'b0, 1'b0);
    bus.flush = 1'b0;
    cyc("sf_after", 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    repeat (3) cyc("drain6", 1'b0, 4'b0000, 1'b0, 1'b0);

    // reset mid-operation, div busy=7
    drv(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    bus.d_md_start = 1'b1;
    bus.d_md_div   = 1'b1;
    bus.d_hilo_use = 1'b1;
    cyc("rs_div", 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    repeat (3) cyc("rs_busy", 1'b0, 4'b0000, 1'b1, 1'b0);
    reset = 1'b0;
    cyc("rs_edge", 1'b0, 4'b0000, 1'b1, 1'b0);
    reset = 1'b1;
    drv(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd1);
    bus.d_hilo_use = 1'b1;
    cyc("rs_mflo", 1'b0, 4'b0000, 1'b0, 1'b0);
    idle();
    repeat (12) cyc("rs_nodone", 1'b0, 4'b0000, 1'b0, 1'b0);

    // random issue stream against a reference model
    t = 0;
    md_end = -100;
    recs.delete();
    for (int n = 0; n < 400; n++) begin
      logic rs_h, rt_h, hl_h, c0_h, st;
      logic [3:0] cs;
      drv(($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
      bus.d_md_start = ($urandom_range(0, 7) == 0);
      bus.d_md_div   = $urandom_range(0, 1) == 1;
      bus.d_hilo_use = bus.d_md_start | ($urandom_range(0, 3) == 0);
      bus.d_eret     = ($urandom_range(0, 5) == 0);
      bus.d_mtc0_epc = ($urandom_range(0, 5) == 0);
      bus.flush      = ($urandom_range(0, 29) == 0);

      rs_h = 1'b0;
      rt_h = 1'b0;
      c0_h = 1'b0;
      foreach (recs[i]) begin
        int age, rem;
        age = t - recs[i].c;
        rem = (recs[i].tn > age - 1) ? recs[i].tn - (age - 1) : 0;
        if (age >= 1 && age <= 3) begin
          if (recs[i].dst == bus.d_rs && rem > int'(bus.d_tuse_rs))
            rs_h = 1'b1;
          if (recs[i].dst == bus.d_rt && rem > int'(bus.d_tuse_rt))
            rt_h = 1'b1;
          if (recs[i].epc && age <= 2)
            c0_h = 1'b1;
        end
      end
      rs_h = rs_h && bus.d_valid && bus.d_rs != 5'd0;
      rt_h = rt_h && bus.d_valid && bus.d_rt != 5'd0;
      c0_h = c0_h && bus.d_valid && bus.d_eret;
      hl_h = bus.d_valid && bus.d_hilo_use && (t <= md_end);
      cs = {c0_h, hl_h, rt_h, rs_h};
      st = |cs;
      cyc("rand", st, cs, (t <= md_end), (t == md_end + 1));

      if (bus.flush) begin
        recs.delete();
        md_end = -100;
      end else if (bus.d_valid && !st) begin
        recs.push_back('{t, bus.d_dst, int'(bus.d_tnew),
                         bus.d_mtc0_epc});
        if (bus.d_md_start)
          md_end = t + (bus.d_md_div ? 10 : 5);
      end
      t++;
      while (recs.size() > 0 && t - recs[0].c > 3)
        void'(recs.pop_front());
    end
    bus.flush = 1'b0;
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
